calc_seq_unit: RTL and testbench

Parametrised, handshaked successor to the 4-bit edge-triggered calculator. It takes two `WIDTH`-bit operands and a 3-bit function code over a valid/ready input channel. Add, subtract and logic results come back in one cycle; multiply and divide run as iterative multi-cycle shift datapaths. The result returns on a valid/ready output channel with an error flag. It sits between the keypad/decode front end and the display formatter.

---
 rtl/calc_pkg.sv | 27 ++
 rtl/calc_iter_muldiv.sv | 69 ++++++
 rtl/calc_seq_unit.sv | 118 +++++++++++
 tb/tb_calc_seq_unit.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared types for the sequential calculator: function codes, FSM states,
// and the iterator mode select.
package calc_pkg;

  typedef enum logic [2:0] {
    FUNC_ADD = 3'b000,
    FUNC_SUB = 3'b001,
    FUNC_MUL = 3'b010,
    FUNC_DIV = 3'b011,
    FUNC_AND = 3'b100,
    FUNC_OR  = 3'b101,
    FUNC_XOR = 3'b110,
    FUNC_ILL = 3'b111
  } func_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic {
    MODE_MUL = 1'b0,
    MODE_DIV = 1'b1
  } mode_e;

endpackage

// File: rtl/calc_iter_muldiv.sv
// Shared iterative multiply / restoring-divide datapath.
// One 2*WIDTH shift register holds {hi, lo}: for mul it is {partial product,
// remaining multiplier bits}; for div it is {remainder, quotient}.
module calc_iter_muldiv
  import calc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  mode_e              mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] result
);

  localparam int RW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  logic [RW-1:0]    sr, sr_nxt;
  logic [WIDTH-1:0] bq;
  logic [WIDTH:0]   acc;
  logic [CW-1:0]    cnt;
  mode_e            mode_q;
  logic             run;

  // done flags the final step; the FSM leaves BUSY on the same edge.
  assign done   = run && (cnt == CW'(WIDTH - 1));
  assign result = sr;

  // One iteration step: add-and-shift-right for mul, trial-subtract-and-shift-left for div.
  always_comb begin
    acc    = '0;
    sr_nxt = sr;
    if (mode_q == MODE_MUL) begin
      acc    = {1'b0, sr[RW-1:WIDTH]} + (sr[0] ? {1'b0, bq} : {(WIDTH+1){1'b0}});
      sr_nxt = {acc, sr[WIDTH-1:1]};
    end else begin
      // Shifted remainder needs WIDTH+1 bits; its MSB after subtract is the borrow.
      acc = sr[RW-1:WIDTH-1] - {1'b0, bq};
      if (!acc[WIDTH]) sr_nxt = {acc[WIDTH-1:0], sr[WIDTH-2:0], 1'b1};
      else             sr_nxt = {sr[RW-2:0], 1'b0};
    end
  end

  // Load operands on start, then step WIDTH times and freeze.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr     <= '0;
      bq     <= '0;
      cnt    <= '0;
      mode_q <= MODE_MUL;
      run    <= 1'b0;
    end else if (start) begin
      sr     <= {{WIDTH{1'b0}}, a};
      bq     <= b;
      cnt    <= '0;
      mode_q <= mode;
      run    <= 1'b1;
    end else if (run) begin
      sr  <= sr_nxt;
      cnt <= cnt + 1'b1;
      if (done) run <= 1'b0;
    end
  end

endmodule

// File: rtl/calc_seq_unit.sv
// Handshaked calculator: single-cycle add/sub/logic, iterative mul/div,
// valid/ready on both sides with an error flag on the result.
module calc_seq_unit
  import calc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  input  logic [2:0]         func,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] res,
  output logic               err
);

  localparam int RW = 2 * WIDTH;

  state_e        state, state_nxt;
  func_e         f;
  mode_e         mode;
  logic          accept, b_zero, is_iter, start, iter_done;
  logic          err_q, sel_iter, err_nxt;
  logic [RW-1:0] res_q, iter_res, single_res, za, zb;

  assign f       = func_e'(func);
  assign za      = {{WIDTH{1'b0}}, op_a};
  assign zb      = {{WIDTH{1'b0}}, op_b};
  assign b_zero  = (op_b == '0);
  assign accept  = in_valid && in_ready;
  assign is_iter = (f == FUNC_MUL) || (f == FUNC_DIV && !b_zero);
  assign mode    = (f == FUNC_DIV) ? MODE_DIV : MODE_MUL;

  // Iterated results are read straight from the shared shift register.
  assign res = sel_iter ? iter_res : res_q;
  assign err = err_q;

  calc_iter_muldiv #(.WIDTH(WIDTH)) u_iter (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .mode   (mode),
    .a      (op_a),
    .b      (op_b),
    .done   (iter_done),
    .result (iter_res)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    start     = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (is_iter) begin
            start     = 1'b1;
            state_nxt = BUSY;
          end else begin
            state_nxt = DONE;
          end
        end
      end
      BUSY: if (iter_done) state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Single-cycle results and error flag for the captured operation.
  always_comb begin
    single_res = '0;
    err_nxt    = 1'b0;
    case (f)
      FUNC_ADD: single_res = za + zb;
      FUNC_SUB: single_res = za - zb;
      FUNC_AND: single_res = za & zb;
      FUNC_OR:  single_res = za | zb;
      FUNC_XOR: single_res = za ^ zb;
      FUNC_DIV: if (b_zero) begin
        single_res = {op_a, {WIDTH{1'b1}}};
        err_nxt    = 1'b1;
      end
      FUNC_ILL: err_nxt = 1'b1;
      default:  single_res = '0;
    endcase
  end

  // Capture result source and value at accept; held untouched until the next accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q    <= '0;
      err_q    <= 1'b0;
      sel_iter <= 1'b0;
    end else if (accept) begin
      res_q    <= single_res;
      err_q    <= err_nxt;
      sel_iter <= is_iter;
    end
  end

endmodule

// File: tb/tb_calc_seq_unit.sv
// Directed bench for calc_seq_unit at WIDTH=8: vector table plus
// back-pressure and mid-operation reset sequences.
module tb_calc_seq_unit;
  import calc_pkg::*;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           out_ready = 1'b0;
  logic [W-1:0]   op_a = '0;
  logic [W-1:0]   op_b = '0;
  logic [2:0]     func = '0;
  logic           in_ready, out_valid, err;
  logic [2*W-1:0] res;

  int total = 0;
  int passed = 0;

  typedef struct {
    logic [2:0]  f;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] r;
    logic        e;
    int          lat;  // edges after the accept edge before out_valid is seen
  } vec_t;

  vec_t vecs[14];

  calc_seq_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .func      (func),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Present one operation for exactly one accept edge.
  task automatic issue(input logic [2:0] f, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    op_a = a; op_b = b; func = f; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    op_a = 8'hA5; op_b = 8'h5A; func = 3'b000;  // later changes must not matter
  endtask

  task automatic wait_out(output int edges, output bit ready_low);
    edges = 0;
    ready_low = 1'b1;
    while (!out_valid && edges < 40) begin
      if (in_ready) ready_low = 1'b0;
      @(posedge clk);
      #1 edges++;
    end
    if (in_ready) ready_low = 1'b0;
  endtask

  task automatic handshake(input string name);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk({name, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
    chk({name, "_ready_rise"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    int  edges;
    bit  rl;
    vecs[0]  = '{FUNC_ADD, 8'd200, 8'd100, 16'h012C, 1'b0, 0};
    vecs[1]  = '{FUNC_SUB, 8'd3,   8'd5,   16'hFFFE, 1'b0, 0};
    vecs[2]  = '{FUNC_MUL, 8'd255, 8'd255, 16'hFE01, 1'b0, 8};
    vecs[3]  = '{FUNC_DIV, 8'd200, 8'd7,   16'h041C, 1'b0, 8};
    vecs[4]  = '{FUNC_DIV, 8'd9,   8'd0,   16'h09FF, 1'b1, 0};
    vecs[5]  = '{FUNC_ILL, 8'h55,  8'h22,  16'h0000, 1'b1, 0};
    vecs[6]  = '{FUNC_XOR, 8'hF0,  8'h3C,  16'h00CC, 1'b0, 0};
    vecs[7]  = '{FUNC_AND, 8'hF0,  8'h3C,  16'h0030, 1'b0, 0};
    vecs[8]  = '{FUNC_OR,  8'hF0,  8'h3C,  16'h00FC, 1'b0, 0};
    vecs[9]  = '{FUNC_ADD, 8'd255, 8'd255, 16'h01FE, 1'b0, 0};
    vecs[10] = '{FUNC_DIV, 8'd255, 8'd1,   16'h00FF, 1'b0, 8};
    vecs[11] = '{FUNC_MUL, 8'd0,   8'd77,  16'h0000, 1'b0, 8};
    vecs[12] = '{FUNC_DIV, 8'd5,   8'd9,   16'h0500, 1'b0, 8};
    vecs[13] = '{FUNC_SUB, 8'd5,   8'd3,   16'h0002, 1'b0, 0};

    // Reset state
    #2;
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_res",       {16'd0, res},       32'd0);
    chk("rst_err",       {31'd0, err},       32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Vector table
    for (int i = 0; i < 14; i++) begin
      issue(vecs[i].f, vecs[i].a, vecs[i].b);
      wait_out(edges, rl);
      chk($sformatf("v%0d_valid", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("v%0d_res", i),   {16'd0, res},       {16'd0, vecs[i].r});
      chk($sformatf("v%0d_err", i),   {31'd0, err},       {31'd0, vecs[i].e});
      chk($sformatf("v%0d_lat", i),   edges,              vecs[i].lat);
      chk($sformatf("v%0d_busy_ready", i), {31'd0, rl},   32'd1);
      handshake($sformatf("v%0d", i));
    end

    // Back-pressure: result holds, in_valid pulses ignored
    issue(FUNC_MUL, 8'd12, 8'd13);
    wait_out(edges, rl);
    chk("bp_lat", edges, 8);
    chk("bp_res0", {16'd0, res}, 32'h009C);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      in_valid = 1'b1; op_a = 8'(c + 1); op_b = 8'd3; func = FUNC_ADD;
      @(posedge clk);
      #1;
      chk($sformatf("bp_res_c%0d", c),   {16'd0, res},       32'h009C);
      chk($sformatf("bp_err_c%0d", c),   {31'd0, err},       32'd0);
      chk($sformatf("bp_valid_c%0d", c), {31'd0, out_valid}, 32'd1);
      chk($sformatf("bp_ready_c%0d", c), {31'd0, in_ready},  32'd0);
    end
    in_valid = 1'b0;
    handshake("bp");
    @(posedge clk);
    #1 chk("bp_no_queued", {31'd0, out_valid}, 32'd0);

    // Reset in the middle of a divide
    issue(FUNC_DIV, 8'd200, 8'd7);
    repeat (3) @(posedge clk);
    #1 chk("mid_busy", {31'd0, in_ready}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_ready", {31'd0, in_ready},  32'd1);
    chk("mid_rst_res",   {16'd0, res},       32'd0);
    chk("mid_rst_err",   {31'd0, err},       32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1 chk("mid_discarded", {31'd0, out_valid}, 32'd0);
    issue(FUNC_ADD, 8'd1, 8'd1);
    wait_out(edges, rl);
    chk("post_rst_lat", edges, 0);
    chk("post_rst_res", {16'd0, res}, 32'h0002);
    chk("post_rst_err", {31'd0, err}, 32'd0);
    handshake("post_rst");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
